// File: rtl/ddr3_burst_writer.sv
// ---------------------------------------------------------------------------
// ddr3_burst_writer
//
// Multi-channel sample writer for the HPS f2h_sdram0 Avalon-MM port.
// Each capture channel feeds its own show-ahead FIFO. A single burst master
// drains the channels into per-channel DDR3 ring regions. Every drain is a
// fixed-length BURST_LEN-beat write, and channels are served round-robin.
//
// Ports
//   clk_clk          single clock (f2h_sdram0 domain)
//   reset_reset_n    asynchronous active-low reset
//   enable           capture enable; low drains the current burst, then flushes
//   ch_valid/ch_data per-channel sample stream (ch i at [i*DATA_W +: DATA_W])
//   ch_ready         per-channel accept (valid & ready = push)
//   avm_*            Avalon-MM burst write master
//   wr_ptr           committed word offset of each channel within its ring
//   overflow         sticky per channel: a sample was offered while FIFO full
//   busy             burst in progress or any FIFO holds data
// ---------------------------------------------------------------------------
module ddr3_burst_writer #(
    parameter int              NUM_CH       = 4,
    parameter int              DATA_W       = 128,
    parameter int              ADDR_W       = 26,
    parameter int              BURST_LEN    = 16,
    parameter int              BURST_W      = 9,
    parameter int              FIFO_DEPTH   = 64,
    parameter longint unsigned BASE_ADDR    = 0,
    parameter longint unsigned REGION_WORDS = 1048576
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_ready,
    output logic [ADDR_W-1:0]          avm_address,
    output logic                       avm_write,
    output logic [DATA_W-1:0]          avm_writedata,
    output logic [DATA_W/8-1:0]        avm_byteenable,
    output logic [BURST_W-1:0]         avm_burstcount,
    input  logic                       avm_waitrequest,
    output logic [NUM_CH*ADDR_W-1:0]   wr_ptr,
    output logic [NUM_CH-1:0]          overflow,
    output logic                       busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_idx_q [NUM_CH];
    logic [PTR_W-1:0]  wr_idx_d [NUM_CH];
    logic [PTR_W-1:0]  rd_idx_q [NUM_CH];
    logic [PTR_W-1:0]  rd_idx_d [NUM_CH];
    logic [LVL_W-1:0]  level_q  [NUM_CH];
    logic [LVL_W-1:0]  level_d  [NUM_CH];
    logic [ADDR_W-1:0] wr_off_q [NUM_CH];
    logic [ADDR_W-1:0] wr_off_d [NUM_CH];

    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [NUM_CH-1:0] push, pop, eligible;
    logic              found;
    logic [CH_W-1:0]   pick;
    logic              beat_ok, last_beat, start, flush;
    logic [ADDR_W:0]   off_sum;

    assign avm_address    = addr_q;
    assign avm_byteenable = '1;
    assign avm_burstcount = BURST_W'(BURST_LEN);
    // Show-ahead: the head word of the granted FIFO is always on the bus.
    assign avm_writedata  = fifo_mem[grant_q][rd_idx_q[grant_q]];

    // Readiness uses the registered level only, so a full FIFO stays
    // not-ready even in a cycle where it is being popped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ready[i] = enable & reset_reset_n & (level_q[i] < LVL_W'(FIFO_DEPTH));
            push[i]     = ch_valid[i] & ch_ready[i];
            eligible[i] = (level_q[i] >= LVL_W'(BURST_LEN));
        end
    end

    // Round-robin pick: first eligible channel at or after rr_q.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && eligible[(int'(rr_q) + k) % NUM_CH]) begin
                found = 1'b1;
                pick  = CH_W'((int'(rr_q) + k) % NUM_CH);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A burst never ends early, regardless of enable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BURST;
            BURST:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. avm_write is decoded from the state so an async reset
    // drops it immediately.
    always_comb begin
        avm_write = (state_q == BURST);
        beat_ok   = avm_write & ~avm_waitrequest;
        last_beat = beat_ok & (beat_q == BEAT_W'(BURST_LEN - 1));
        start     = (state_q == IDLE) & enable & found;
        flush     = (state_q == IDLE) & ~enable;
    end

    // FIFO pointers and fill levels; flushing only happens in IDLE.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]      = beat_ok & (grant_q == CH_W'(i));
            wr_idx_d[i] = wr_idx_q[i] + PTR_W'(push[i]);
            rd_idx_d[i] = rd_idx_q[i] + PTR_W'(pop[i]);
            level_d[i]  = level_q[i] + LVL_W'(push[i]) - LVL_W'(pop[i]);
            if (flush) begin
                wr_idx_d[i] = '0;
                rd_idx_d[i] = '0;
                level_d[i]  = '0;
            end
        end
    end

    // Burst bookkeeping: grant/address capture, beat count, ring offsets,
    // round-robin advance and sticky overflow.
    always_comb begin
        grant_d    = grant_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        rr_d       = rr_q;
        overflow_d = overflow_q;
        off_sum    = {1'b0, wr_off_q[grant_q]} + (ADDR_W + 1)'(BURST_LEN);
        for (int i = 0; i < NUM_CH; i++) begin
            wr_off_d[i] = wr_off_q[i];
        end
        if (start) begin
            grant_d = pick;
            addr_d  = ADDR_W'(64'(BASE_ADDR) + 64'(pick) * 64'(REGION_WORDS)
                              + 64'(wr_off_q[pick]));
            beat_d  = '0;
        end
        if (beat_ok) begin
            beat_d = beat_q + BEAT_W'(1);
        end
        if (last_beat) begin
            wr_off_d[grant_q] = (off_sum == (ADDR_W + 1)'(REGION_WORDS)) ? '0 : off_sum[ADDR_W-1:0];
            rr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (enable && ch_valid[i] && level_q[i] == LVL_W'(FIFO_DEPTH)) begin
                overflow_d[i] = 1'b1;
            end
        end
        if (flush) begin
            overflow_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_off_d[i] = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow_q <= '0;
            grant_q    <= '0;
            rr_q       <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_idx_q[i] <= '0;
                rd_idx_q[i] <= '0;
                level_q[i]  <= '0;
                wr_off_q[i] <= '0;
            end
        end else begin
            overflow_q <= overflow_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_idx_q[i] <= wr_idx_d[i];
                rd_idx_q[i] <= rd_idx_d[i];
                level_q[i]  <= level_d[i];
                wr_off_q[i] <= wr_off_d[i];
            end
        end
    end

    // FIFO storage has no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_idx_q[i]] <= ch_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Status outputs.
    always_comb begin
        busy     = (state_q != IDLE);
        overflow = overflow_q;
        for (int i = 0; i < NUM_CH; i++) begin
            busy = busy | (level_q[i] != '0);
            wr_ptr[i*ADDR_W +: ADDR_W] = wr_off_q[i];
        end
    end

endmodule
